// File: rtl/ofm_axi_pkg.sv
// Shared constants, FSM state type and helpers for the OFM AXI write buffer.
package ofm_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ADDR,
    ST_DATA,
    ST_RESP,
    ST_FIN
  } wb_state_t;

  // AXI AxSIZE encoding for a full-width beat of data_width bits.
  function automatic logic [2:0] axi_size(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/ofm_axi_write_buffer_fifo.sv
// First-word-fallthrough synchronous FIFO. The head is read combinationally so
// WDATA follows the oldest word with no latency; push+pop is legal at any
// level, including full, because the write and the head read hit the array
// independently.
module sync_fifo_fwft #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 512,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [AW:0]      count_next;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == (AW + 1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign level   = count_reg;
  assign head    = mem[rd_ptr_reg];
  assign pop_ok  = pop && !empty;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);

  // Occupancy update from the accepted push/pop pair.
  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + (AW + 1)'(1);
      2'b01:   count_next = count_reg - (AW + 1)'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage array write; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/ofm_axi_write_buffer.sv
// Buffers OFM words from the functional unit and drains them to DDR as AXI4
// INCR bursts, one burst outstanding at a time. A burst is only announced on
// AW once all of its beats are already buffered, so WVALID never gaps.
module ofm_axi_write_buffer
  import ofm_axi_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int FIFO_DEPTH = 512,
  parameter int BURST_LEN  = 16,
  parameter int CNT_WIDTH  = 24
) (
  input  logic                      M_AXI_ACLK,
  input  logic                      M_AXI_ARESETN,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  input  logic [CNT_WIDTH-1:0]      total_words,
  input  logic                      ofm_write_en,
  input  logic [DATA_WIDTH-1:0]     ofm_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [ID_WIDTH-1:0]       M_AXI_AWID,
  output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [7:0]                M_AXI_AWLEN,
  output logic [2:0]                M_AXI_AWSIZE,
  output logic [1:0]                M_AXI_AWBURST,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                      M_AXI_WLAST,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  output logic                      busy,
  output logic                      done,
  output logic                      error
);

  localparam int BYTES_PER_BEAT = DATA_WIDTH / 8;
  localparam int BEAT_W         = $clog2(BURST_LEN) + 1;

  wb_state_t             state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [CNT_WIDTH-1:0]  remain_reg, remain_next;
  logic [BEAT_W-1:0]     beats_reg, beats_next;
  logic [BEAT_W-1:0]     beat_cnt_reg, beat_cnt_next;
  logic                  error_reg, error_next;

  logic [BEAT_W-1:0]     beats_calc;
  logic [ADDR_WIDTH-1:0] burst_bytes;
  logic                  level_ok;
  logic                  w_hs;
  logic                  w_last;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  overflow;

  sync_fifo_fwft #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (M_AXI_ACLK),
    .rst_n     (M_AXI_ARESETN),
    .push      (ofm_write_en),
    .push_data (ofm_data),
    .pop       (w_hs),
    .head      (M_AXI_WDATA),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Burst sizing, handshakes and overflow detection.
  always_comb begin
    beats_calc = BEAT_W'(BURST_LEN);
    if (remain_reg < CNT_WIDTH'(BURST_LEN)) begin
      beats_calc = BEAT_W'(remain_reg);
    end
  end

  assign level_ok    = (CNT_WIDTH'(fifo_level) >= CNT_WIDTH'(beats_calc));
  assign burst_bytes = ADDR_WIDTH'(beats_reg) * ADDR_WIDTH'(BYTES_PER_BEAT);
  assign w_hs        = (state_reg == ST_DATA) && M_AXI_WREADY && !fifo_empty;
  assign w_last      = (state_reg == ST_DATA) && (beat_cnt_reg == beats_reg - BEAT_W'(1));
  assign overflow    = ofm_write_en && fifo_full && !w_hs;

  // Next-state and datapath updates for the burst sequencer.
  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    remain_next   = remain_reg;
    beats_next    = beats_reg;
    beat_cnt_next = beat_cnt_reg;
    error_next    = error_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          addr_next   = base_addr;
          remain_next = total_words;
          error_next  = 1'b0;
          state_next  = (total_words == '0) ? ST_FIN : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (level_ok) begin
          beats_next = beats_calc;
          state_next = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (M_AXI_AWREADY) begin
          beat_cnt_next = '0;
          state_next    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_hs) begin
          if (w_last) begin
            addr_next   = addr_reg + burst_bytes;
            remain_next = remain_reg - CNT_WIDTH'(beats_reg);
            state_next  = ST_RESP;
          end else begin
            beat_cnt_next = beat_cnt_reg + BEAT_W'(1);
          end
        end
      end
      ST_RESP: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != AXI_RESP_OKAY) error_next = 1'b1;
          state_next = (remain_reg == '0) ? ST_FIN : ST_WAIT;
        end
      end
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    // A dropped word is an error even in the cycle a start clears it.
    if (overflow) error_next = 1'b1;
  end

  // State and datapath registers; reset abandons any in-flight burst.
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= '0;
      remain_reg   <= '0;
      beats_reg    <= '0;
      beat_cnt_reg <= '0;
      error_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      remain_reg   <= remain_next;
      beats_reg    <= beats_next;
      beat_cnt_reg <= beat_cnt_next;
      error_reg    <= error_next;
    end
  end

  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = addr_reg;
  assign M_AXI_AWLEN   = 8'(beats_reg - BEAT_W'(1));
  assign M_AXI_AWSIZE  = axi_size(DATA_WIDTH);
  assign M_AXI_AWBURST = AXI_BURST_INCR;
  assign M_AXI_AWVALID = (state_reg == ST_ADDR);
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WLAST   = w_last;
  assign M_AXI_WVALID  = (state_reg == ST_DATA);
  assign M_AXI_BREADY  = (state_reg == ST_RESP);
  assign busy          = (state_reg != ST_IDLE) && (state_reg != ST_FIN);
  assign done          = (state_reg == ST_FIN);
  assign error         = error_reg;

endmodule

// File: tb/tb_ofm_axi_write_buffer.sv
// Directed bench for ofm_axi_write_buffer: an AXI slave model with optional
// random stalls, a capture monitor, and one task per scenario.
module tb_ofm_axi_write_buffer;

  localparam int DW = 256;
  localparam int AW = 32;
  localparam int IW = 4;
  localparam int FD = 32;
  localparam int BL = 16;
  localparam int CW = 24;
  localparam int LW = $clog2(FD) + 1;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] total_words = '0;
  logic          ofm_write_en = 1'b0;
  logic [DW-1:0] ofm_data = '0;
  logic [LW-1:0] fifo_level;
  logic [IW-1:0] awid;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          awvalid;
  logic          awready = 1'b1;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic          wlast;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp = 2'b00;
  logic          bvalid = 1'b0;
  logic          bready;
  logic          busy;
  logic          done;
  logic          error;

  // slave controls (written by the test process only)
  logic stall = 1'b0;
  logic w_manual = 1'b0;
  logic w_manual_val = 1'b0;
  logic w_auto = 1'b1;
  int   err_burst = -1;
  int   clr_epoch = 0;

  assign wready = w_manual ? w_manual_val : w_auto;

  // monitor state (written by the monitor only)
  logic [AW-1:0] aw_addr_q[$];
  logic [7:0]    aw_len_q[$];
  logic [DW-1:0] w_data_q[$];
  int            w_last_q[$];
  int            b_cnt = 0, b_idx = 0, done_cnt = 0, stab_err = 0, pending_b = 0;
  int            mon_epoch = 0;
  logic          aw_wait = 1'b0, w_wait = 1'b0, prev_wlast = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [7:0]    prev_len = '0;
  logic [DW-1:0] prev_wdata = '0;

  logic [DW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ofm_axi_write_buffer #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .ID_WIDTH (IW),
    .FIFO_DEPTH (FD), .BURST_LEN (BL), .CNT_WIDTH (CW)
  ) dut (
    .M_AXI_ACLK (clk), .M_AXI_ARESETN (aresetn),
    .start (start), .base_addr (base_addr), .total_words (total_words),
    .ofm_write_en (ofm_write_en), .ofm_data (ofm_data), .fifo_level (fifo_level),
    .M_AXI_AWID (awid), .M_AXI_AWADDR (awaddr), .M_AXI_AWLEN (awlen),
    .M_AXI_AWSIZE (awsize), .M_AXI_AWBURST (awburst), .M_AXI_AWVALID (awvalid),
    .M_AXI_AWREADY (awready), .M_AXI_WDATA (wdata), .M_AXI_WSTRB (wstrb),
    .M_AXI_WLAST (wlast), .M_AXI_WVALID (wvalid), .M_AXI_WREADY (wready),
    .M_AXI_BRESP (bresp), .M_AXI_BVALID (bvalid), .M_AXI_BREADY (bready),
    .busy (busy), .done (done), .error (error)
  );

  // Slave: ready/response drive just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      w_auto  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pending_b > 0) begin
        if (!bvalid) begin
          bvalid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
          bresp  = (b_idx == err_burst) ? 2'b10 : 2'b00;
        end
      end else begin
        bvalid = 1'b0;
        bresp  = 2'b00;
      end
    end
  end

  // Monitor: records handshakes of the coming edge and stability violations.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_epoch != clr_epoch) begin
        aw_addr_q.delete(); aw_len_q.delete(); w_data_q.delete(); w_last_q.delete();
        b_cnt = 0; b_idx = 0; done_cnt = 0; stab_err = 0; pending_b = 0;
        mon_epoch = clr_epoch;
      end
      if (!aresetn) begin
        aw_wait = 1'b0;
        w_wait  = 1'b0;
      end else begin
        if (aw_wait && !(awvalid && awaddr == prev_addr && awlen == prev_len)) stab_err++;
        if (w_wait && !(wvalid && wdata == prev_wdata && wlast == prev_wlast)) stab_err++;
        if (awvalid && awready) begin
          aw_addr_q.push_back(awaddr);
          aw_len_q.push_back(awlen);
        end
        if (wvalid && wready) begin
          w_data_q.push_back(wdata);
          if (wlast) begin
            w_last_q.push_back(w_data_q.size());
            pending_b++;
          end
        end
        if (bvalid && bready) begin
          b_cnt++;
          b_idx++;
          pending_b--;
        end
        if (done) done_cnt++;
        aw_wait = awvalid && !awready;
        w_wait  = wvalid && !wready;
        prev_addr = awaddr; prev_len = awlen; prev_wdata = wdata; prev_wlast = wlast;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] mk_word(input int tag, input int i);
    logic [31:0] w;
    w = {tag[15:0], i[15:0]};
    return {8{w}};
  endfunction

  function automatic int data_mismatches();
    int mm = 0;
    if (w_data_q.size() != exp_q.size()) mm++;
    for (int i = 0; i < exp_q.size() && i < w_data_q.size(); i++)
      if (w_data_q[i] !== exp_q[i]) mm++;
    return mm;
  endfunction

  task automatic clear_capture();
    clr_epoch++;
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input int n);
    @(negedge clk);
    base_addr   = b;
    total_words = CW'(n);
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int n, input int tag);
    for (int i = 0; i < n; i++) begin
      int g = 0;
      @(negedge clk);
      while (fifo_level >= LW'(FD - 2) && g < 4000) begin
        ofm_write_en = 1'b0;
        @(negedge clk);
        g++;
      end
      ofm_write_en = 1'b1;
      ofm_data     = mk_word(tag, i);
      exp_q.push_back(mk_word(tag, i));
    end
    @(negedge clk);
    ofm_write_en = 1'b0;
  endtask

  task automatic wait_done(output bit timed_out);
    int c = 0;
    while (done_cnt == 0 && c < 5000) begin
      @(negedge clk);
      c++;
    end
    timed_out = (done_cnt == 0);
    repeat (6) @(negedge clk);
  endtask

  task automatic run_layer(input logic [AW-1:0] b, input int n, input int tag, output bit timed_out);
    clear_capture();
    fork
      feed(n, tag);
      pulse_start(b, n);
    join
    wait_done(timed_out);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (awvalid !== 1'b0) begin errors++; $display("FAIL reset_awvalid: got %b want 0", awvalid); end
    checks++; if (wvalid !== 1'b0) begin errors++; $display("FAIL reset_wvalid: got %b want 0", wvalid); end
    checks++; if ({busy, done, error, bready} !== 4'b0000) begin errors++; $display("FAIL reset_status: busy/done/error/bready=%b want 0000", {busy, done, error, bready}); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    checks++; if ({awid, awburst, awsize} !== {4'h0, 2'b01, 3'd5}) begin errors++; $display("FAIL reset_const: awid=%0h awburst=%b awsize=%0d want 0/01/5", awid, awburst, awsize); end
    checks++; if (wstrb !== {(DW/8){1'b1}}) begin errors++; $display("FAIL reset_wstrb: got %h want all ones", wstrb); end
    aresetn = 1'b1;
    repeat (2) @(negedge clk);
    $display("test_reset: done");
  endtask

  task automatic test_basic();
    bit to;
    logic [AW-1:0] ea[3];
    logic [7:0]    el[3];
    int            ew[3];
    ea = '{32'h4000_0000, 32'h4000_0200, 32'h4000_0400};
    el = '{8'd15, 8'd15, 8'd7};
    ew = '{16, 32, 40};
    run_layer(32'h4000_0000, 40, 1, to);
    checks++; if (to) begin errors++; $display("FAIL basic_done_timeout: done not seen, required within 5000 cycles"); end
    checks++; if (aw_addr_q.size() !== 3) begin errors++; $display("FAIL basic_aw_count: got %0d want 3", aw_addr_q.size()); end
    for (int i = 0; i < 3 && i < aw_addr_q.size(); i++) begin
      checks++; if (aw_addr_q[i] !== ea[i] || aw_len_q[i] !== el[i]) begin errors++; $display("FAIL basic_aw%0d: addr=%h len=%0d want %h/%0d", i, aw_addr_q[i], aw_len_q[i], ea[i], el[i]); end
    end
    checks++; if (w_last_q.size() !== 3) begin errors++; $display("FAIL basic_wlast_count: got %0d want 3", w_last_q.size()); end
    for (int i = 0; i < 3 && i < w_last_q.size(); i++) begin
      checks++; if (w_last_q[i] !== ew[i]) begin errors++; $display("FAIL basic_wlast%0d: beat %0d want %0d", i, w_last_q[i], ew[i]); end
    end
    checks++; if (data_mismatches() !== 0) begin errors++; $display("FAIL basic_data: %0d mismatches (got %0d words) want 0 (40 words)", data_mismatches(), w_data_q.size()); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_once: got %0d pulses want 1", done_cnt); end
    checks++; if ({busy, error} !== 2'b00 || fifo_level !== '0) begin errors++; $display("FAIL basic_final: busy=%b error=%b level=%0d want 0/0/0", busy, error, fifo_level); end
    $display("test_basic: %0d bursts, %0d words", aw_addr_q.size(), w_data_q.size());
  endtask

  task automatic test_stall();
    bit to;
    stall = 1'b1;
    run_layer(32'h1000_0000, 100, 2, to);
    stall = 1'b0;
    checks++; if (to) begin errors++; $display("FAIL stall_done_timeout: done not seen, required within 5000 cycles"); end
    checks++; if (aw_addr_q.size() !== 7) begin errors++; $display("FAIL stall_aw_count: got %0d want 7", aw_addr_q.size()); end
    if (aw_addr_q.size() == 7) begin
      checks++; if (aw_addr_q[6] !== 32'h1000_0C00 || aw_len_q[6] !== 8'd3) begin errors++; $display("FAIL stall_last_aw: addr=%h len=%0d want 10000c00/3", aw_addr_q[6], aw_len_q[6]); end
    end
    checks++; if (data_mismatches() !== 0) begin errors++; $display("FAIL stall_data: %0d mismatches (got %0d words) want 0 (100 words)", data_mismatches(), w_data_q.size()); end
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL stall_stable: %0d valid/payload changes while stalled, want 0", stab_err); end
    checks++; if (done_cnt !== 1 || b_cnt !== 7) begin errors++; $display("FAIL stall_done_b: done=%0d b=%0d want 1/7", done_cnt, b_cnt); end
    $display("test_stall: %0d bursts, %0d words", aw_addr_q.size(), w_data_q.size());
  endtask

  task automatic test_zero_words();
    clear_capture();
    pulse_start(32'h4000_0000, 0);
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_done: done=%b busy=%b want 1/0", done, busy); end
    repeat (4) @(negedge clk);
    checks++; if (done_cnt !== 1 || aw_addr_q.size() !== 0) begin errors++; $display("FAIL zero_once: done=%0d aw=%0d want 1/0", done_cnt, aw_addr_q.size()); end
    $display("test_zero_words: done pulses=%0d", done_cnt);
  endtask

  task automatic test_overflow();
    bit to;
    int c;
    clear_capture();
    for (int i = 0; i < FD + 1; i++) begin
      @(negedge clk);
      ofm_write_en = 1'b1;
      ofm_data     = mk_word(5, i);
      if (i < FD) exp_q.push_back(mk_word(5, i));
      if (i == FD) begin
        checks++; if (fifo_level !== LW'(FD) || error !== 1'b0) begin errors++; $display("FAIL ovf_full: level=%0d error=%b want %0d/0", fifo_level, error, FD); end
      end
    end
    @(negedge clk);
    ofm_write_en = 1'b0;
    checks++; if (fifo_level !== LW'(FD) || error !== 1'b1) begin errors++; $display("FAIL ovf_drop: level=%0d error=%b want %0d/1", fifo_level, error, FD); end
    w_manual = 1'b1;
    w_manual_val = 1'b0;
    pulse_start(32'h2000_0000, FD + 1);
    c = 0;
    while (!wvalid && c < 50) begin @(negedge clk); c++; end
    checks++; if (wvalid !== 1'b1 || fifo_level !== LW'(FD)) begin errors++; $display("FAIL ovf_wvalid: wvalid=%b level=%0d want 1/%0d", wvalid, fifo_level, FD); end
    w_manual_val = 1'b1;
    ofm_write_en = 1'b1;
    ofm_data     = mk_word(5, 99);
    exp_q.push_back(mk_word(5, 99));
    @(negedge clk);
    w_manual_val = 1'b0;
    ofm_write_en = 1'b0;
    checks++; if (fifo_level !== LW'(FD) || error !== 1'b0) begin errors++; $display("FAIL ovf_push_pop: level=%0d error=%b want %0d/0", fifo_level, error, FD); end
    w_manual = 1'b0;
    wait_done(to);
    checks++; if (to) begin errors++; $display("FAIL ovf_done_timeout: done not seen, required within 5000 cycles"); end
    checks++; if (data_mismatches() !== 0) begin errors++; $display("FAIL ovf_data: %0d mismatches (got %0d words) want 0 (33 words)", data_mismatches(), w_data_q.size()); end
    checks++; if (done_cnt !== 1 || fifo_level !== '0) begin errors++; $display("FAIL ovf_final: done=%0d level=%0d want 1/0", done_cnt, fifo_level); end
    $display("test_overflow: %0d words drained", w_data_q.size());
  endtask

  task automatic test_bresp_error();
    bit to;
    err_burst = 1;
    run_layer(32'h3000_0000, 48, 3, to);
    err_burst = -1;
    checks++; if (to) begin errors++; $display("FAIL bresp_done_timeout: done not seen, required within 5000 cycles"); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL bresp_error: got %b want 1", error); end
    checks++; if (done_cnt !== 1 || b_cnt !== 3) begin errors++; $display("FAIL bresp_done_b: done=%0d b=%0d want 1/3", done_cnt, b_cnt); end
    checks++; if (data_mismatches() !== 0) begin errors++; $display("FAIL bresp_data: %0d mismatches want 0", data_mismatches()); end
    $display("test_bresp_error: error=%b", error);
  endtask

  task automatic test_reset_mid();
    bit to;
    int c;
    clear_capture();
    w_manual = 1'b1;
    w_manual_val = 1'b0;
    feed(16, 7);
    pulse_start(32'h5000_0000, 16);
    c = 0;
    while (!wvalid && c < 50) begin @(negedge clk); c++; end
    checks++; if (wvalid !== 1'b1) begin errors++; $display("FAIL rstmid_in_data: wvalid=%b want 1", wvalid); end
    aresetn = 1'b0;
    @(negedge clk);
    checks++; if ({awvalid, wvalid, busy} !== 3'b000 || fifo_level !== '0) begin errors++; $display("FAIL rstmid_clear: aw/w/busy=%b level=%0d want 000/0", {awvalid, wvalid, busy}, fifo_level); end
    aresetn = 1'b1;
    w_manual = 1'b0;
    run_layer(32'h5000_0000, 20, 8, to);
    checks++; if (to) begin errors++; $display("FAIL rstmid_done_timeout: done not seen, required within 5000 cycles"); end
    checks++; if (aw_addr_q.size() !== 2) begin errors++; $display("FAIL rstmid_aw_count: got %0d want 2", aw_addr_q.size()); end
    if (aw_addr_q.size() == 2) begin
      checks++; if (aw_addr_q[1] !== 32'h5000_0200 || aw_len_q[1] !== 8'd3) begin errors++; $display("FAIL rstmid_aw1: addr=%h len=%0d want 50000200/3", aw_addr_q[1], aw_len_q[1]); end
    end
    checks++; if (data_mismatches() !== 0 || done_cnt !== 1 || error !== 1'b0) begin errors++; $display("FAIL rstmid_rerun: mismatches=%0d done=%0d error=%b want 0/1/0", data_mismatches(), done_cnt, error); end
    $display("test_reset_mid: rerun %0d words", w_data_q.size());
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_words();
    test_overflow();
    test_bresp_error();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
